// File: rtl/cnn_pkg.sv
// Shared types and dimension constants for the CNN layer sequencers.
package cnn_pkg;

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;
    localparam int DEF_K     = 5;

    localparam int OUT_W = DEF_IMG_W - DEF_K + 1;
    localparam int OUT_H = DEF_IMG_H - DEF_K + 1;
    localparam int TAPS  = DEF_K * DEF_K;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAP,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/win_addr_gen.sv
// Kernel-window tap counters; registers the image read address and tap index
// so both appear in the same cycle as the tap they describe.
module win_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              tap_go,    // a tap is issued next cycle
    input  logic              first,     // that tap is tap 0 of a new pixel
    input  logic [4:0]        row,       // pixel the next tap belongs to
    input  logic [4:0]        col,
    output logic              last,      // current tap is the final one
    output logic [ADDR_W-1:0] pix_addr,
    output logic [4:0]        tap_idx
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;

    logic [KW-1:0] kr, kc, kr_n, kc_n;

    always_comb begin
        kr_n = '0;
        kc_n = '0;
        if (!first) begin
            if (int'(kc) == K - 1) begin
                kr_n = kr + 1'b1;
            end else begin
                kr_n = kr;
                kc_n = kc + 1'b1;
            end
        end
    end

    assign last = (int'(kr) == K - 1) && (int'(kc) == K - 1);

    // Outside a tap everything parks at zero, so a fresh pixel always starts clean.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            kr       <= '0;
            kc       <= '0;
            pix_addr <= '0;
            tap_idx  <= '0;
        end else if (tap_go) begin
            kr       <= kr_n;
            kc       <= kc_n;
            pix_addr <= ADDR_W'((int'(row) + int'(kr_n)) * IMG_W + int'(col) + int'(kc_n));
            tap_idx  <= 5'(int'(kr_n) * K + int'(kc_n));
        end else begin
            kr       <= '0;
            kc       <= '0;
            pix_addr <= '0;
            tap_idx  <= '0;
        end
    end

endmodule

// File: rtl/conv1_sched.sv
// Conv layer 1 sequencer: raster-walks output pixels, issues K*K taps per pixel,
// waits out the MAC latency and hands each pixel to pool1 over valid/ready.
module conv1_sched
    import cnn_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int K       = DEF_K,
    parameter int MAC_LAT = 1,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              out_ready,
    output logic              weight_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [4:0]        tap_idx,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_valid,
    output logic [4:0]        out_row,
    output logic [4:0]        out_col,
    output logic              busy,
    output logic              done
);

    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t        state, state_n;
    logic [4:0]    row, col, row_n, col_n;
    logic [DW-1:0] drain_cnt;
    logic          last_tap, last_pix;

    assign last_pix = (int'(row) == OH - 1) && (int'(col) == OW - 1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            col       <= col_n;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_TAP;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            S_TAP: begin
                if (last_tap) state_n = (MAC_LAT > 0) ? S_DRAIN : S_OUT;
            end
            S_DRAIN: begin
                if (int'(drain_cnt) == MAC_LAT - 1) state_n = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_pix) begin
                        state_n = S_DONE;
                        row_n   = '0;
                        col_n   = '0;
                    end else begin
                        state_n = S_TAP;
                        if (int'(col) == OW - 1) begin
                            col_n = '0;
                            row_n = row + 1'b1;
                        end else begin
                            col_n = col + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Address generator is fed next-cycle coordinates so its registered outputs line up with TAP.
    win_addr_gen #(
        .IMG_W  (IMG_W),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk      (clk),
        .n_reset  (n_reset),
        .tap_go   (state_n == S_TAP),
        .first    (state != S_TAP),
        .row      (row_n),
        .col      (col_n),
        .last     (last_tap),
        .pix_addr (pix_addr),
        .tap_idx  (tap_idx)
    );

    assign weight_en = (state == S_TAP);
    assign acc_en    = (state == S_TAP);
    assign acc_clr   = (state == S_TAP) && (tap_idx == 5'd0);
    assign out_valid = (state == S_OUT);
    assign out_row   = out_valid ? row : '0;
    assign out_col   = out_valid ? col : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_conv1_sched.sv
// Scoreboard bench for conv1_sched: a window-walk reference model fills tap and
// pixel queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_conv1_sched;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int K       = 5;
    localparam int MAC_LAT = 1;
    localparam int ADDR_W  = 10;
    localparam int OW      = IMG_W - K + 1;
    localparam int OH      = IMG_H - K + 1;
    localparam int PIX_CYC = K * K + MAC_LAT + 1;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic              weight_en, acc_clr, acc_en, out_valid, busy, done;
    logic [ADDR_W-1:0] pix_addr;
    logic [4:0]        tap_idx, out_row, out_col;

    conv1_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .MAC_LAT(MAC_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (start),
        .out_ready (out_ready),
        .weight_en (weight_en),
        .pix_addr  (pix_addr),
        .tap_idx   (tap_idx),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int idx; bit clr; } tap_t;
    typedef struct { int r; int c; } pix_t;

    tap_t tq[$];
    pix_t oq[$];
    tap_t et;
    pix_t ep;

    int         vectors = 0, errors = 0;
    int         hs_cnt = 0, done_cnt = 0;
    bit         mon_en = 0, prev_wait = 0, final_hs = 0;
    logic [4:0] prev_row = '0, prev_col = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, weight_en, pix_addr, tap_idx, acc_clr, acc_en,
                out_valid, out_row, out_col, busy, done};
    endfunction

    // Reference: every output pixel in raster order, every tap of its window.
    task automatic push_layer();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                for (int t = 0; t < K * K; t++)
                    tq.push_back('{(r + t / K) * IMG_W + c + t % K, t, t == 0});
                oq.push_back('{r, c});
            end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (weight_en) begin
                if (tq.size() == 0) check("tap_unexpected", 1, 0);
                else begin
                    et = tq.pop_front();
                    check("pix_addr", pix_addr, et.addr);
                    check("tap_idx", tap_idx, et.idx);
                    check("acc_clr", acc_clr, et.clr);
                    check("acc_en", acc_en, 1);
                    check("tap_during_out", out_valid, 0);
                end
            end else begin
                check("acc_idle", {acc_en, acc_clr}, 0);
            end
            if (prev_wait) begin
                check("valid_held", out_valid, 1);
                check("pos_held", {out_row, out_col}, {prev_row, prev_col});
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (oq.size() == 0) check("pix_unexpected", 1, 0);
                else begin
                    ep = oq.pop_front();
                    check("out_row", out_row, ep.r);
                    check("out_col", out_col, ep.c);
                end
            end
            if (done || final_hs) check("done_timing", done, final_hs);
            if (done) done_cnt++;
            final_hs  = out_valid && out_ready && (out_row == OH - 1) && (out_col == OW - 1);
            prev_wait = out_valid && !out_ready;
            prev_row  = out_row;
            prev_col  = out_col;
        end
    end

    // One layer run; edge numbers count from the edge that samples start (edge 0).
    task automatic run_layer(input bit rnd, input int rst_at, output int n_done, output int first_ov);
        int n = 0;
        int bp = 0;
        n_done = -1;
        first_ov = -1;
        push_layer();
        hs_cnt = 0;
        done_cnt = 0;
        mon_en = 1;
        @(posedge clk); #1 start = 1; out_ready = 1;
        @(posedge clk); #1 start = 0;
        while (n < 30000) begin
            if (n == rst_at) begin
                mon_en = 0;
                n_reset = 0;
                #1 check("reset_outputs_mid", all_outs(), 0);
                tq.delete();
                oq.delete();
                prev_wait = 0;
                final_hs = 0;
                @(posedge clk); #1 n_reset = 1;
                return;
            end
            if (out_valid && first_ov < 0) first_ov = n;
            if (done) begin
                n_done = n;
                check("busy_in_done", busy, 1);
                start = 1;
                @(posedge clk); #1 start = 0;
                check("busy_after_done", {busy, done, weight_en}, 0);
                break;
            end
            start = (n == 50) || (rnd && $urandom_range(15) == 0);
            if (rnd) begin
                if (out_valid && out_row == 0 && out_col == 0 && bp < 10) begin
                    out_ready = 0;
                    bp++;
                end else begin
                    out_ready = ($urandom_range(3) != 0);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        start = 0;
    endtask

    task automatic end_checks();
        check("taps_left", tq.size(), 0);
        check("pix_left", oq.size(), 0);
        check("handshakes", hs_cnt, OW * OH);
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        int nd, fo;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", all_outs(), 0);
        n_reset = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("idle_quiet", {busy, done, weight_en, out_valid}, 0);
        end

        run_layer(0, -1, nd, fo);
        check("done_edge", nd, OW * OH * PIX_CYC);
        check("first_valid_edge", fo, K * K + MAC_LAT);
        end_checks();

        run_layer(1, -1, nd, fo);
        check("done_seen_rnd", nd > 0, 1);
        end_checks();

        run_layer(0, 300, nd, fo);
        check("no_done_after_reset", done_cnt, 0);
        repeat (3) @(posedge clk);
        #1 check("idle_after_reset", {busy, weight_en}, 0);

        run_layer(0, -1, nd, fo);
        check("done_edge_restart", nd, OW * OH * PIX_CYC);
        check("first_valid_restart", fo, K * K + MAC_LAT);
        end_checks();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
